// File: rtl/uart_alu_interface.sv
// Glue between the UART receiver/transmitter and the ALU: collects A, B and opcode bytes,
// registers them for the ALU, captures the result and requests one transmit per frame.
module uart_alu_interface #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_opcode,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    localparam int unsigned NbCnt = $clog2(TIMEOUT);
    localparam logic [NbCnt-1:0] CntLast = NbCnt'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StCompute,
        StSend,
        StWaitTx
    } state_e;

    state_e             state_q, state_d;
    logic [NbCnt-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   opcode_q, opcode_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StWaitA;
            cnt_q     <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            opcode_q  <= '0;
            tx_data_q <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            opcode_q  <= opcode_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy = (state_q == StCompute) || (state_q == StSend) || (state_q == StWaitTx);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        opcode_d  = opcode_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            StWaitA: begin
                if (i_rx_done) begin
                    data_a_d = i_rx_data;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                // A byte landing on the terminal count wins over the timeout.
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = StWaitOp;
                end else if (cnt_q == CntLast) begin
                    state_d   = StWaitA;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + NbCnt'(1);
                end
            end
            StWaitOp: begin
                if (i_rx_done) begin
                    opcode_d = i_rx_data[NB_OP-1:0];
                    state_d  = StCompute;
                end else if (cnt_q == CntLast) begin
                    state_d   = StWaitA;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + NbCnt'(1);
                end
            end
            StCompute: begin
                tx_data_d = i_alu_result;
                state_d   = StSend;
            end
            StSend: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: begin
                state_d = StWaitA;
            end
        endcase

        // Bytes arriving while a result is in flight are dropped and flagged.
        if (busy && i_rx_done) begin
            overrun_d = 1'b1;
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == StSend);
    assign o_busy     = busy;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized byte/tx_done/reset traffic.
module tb_uart_alu_interface;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] opcode;
    logic       tx_start, busy, timeout, overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .NB_DATA(NB_DATA),
        .NB_OP  (NB_OP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_tx_done   (tx_done),
        .i_alu_result(alu_result),
        .o_data_a    (data_a),
        .o_data_b    (data_b),
        .o_opcode    (opcode),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy),
        .o_timeout   (timeout),
        .o_overrun   (overrun)
    );

    // ALU stub: 0x20 add, 0x22 subtract, anything else xor (all wrap to 8 bits).
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_f(data_a, data_b, opcode);

    // Frame-level model: bytes collected so far, result pipeline distance, idle clocks.
    typedef struct packed {
        int         nbytes;
        int         pipe;
        bit         wait_tx;
        int         idle;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] tx;
        bit         timeout;
        bit         overrun;
    } model_t;

    function automatic model_t step(input model_t m, input logic r, input logic rxd,
                                    input logic [7:0] rxb, input logic txd);
        model_t n;
        n = m;
        n.timeout = 1'b0;
        if (r) return '0;
        if (m.pipe != 0 || m.wait_tx) begin
            if (rxd) n.overrun = 1'b1;
            if (m.pipe == 2) begin
                n.tx   = alu_f(m.a, m.b, m.op);
                n.pipe = 1;
            end else if (m.pipe == 1) begin
                n.pipe    = 0;
                n.wait_tx = 1'b1;
            end else if (txd) begin
                n.wait_tx = 1'b0;
            end
        end else if (rxd) begin
            n.idle = 0;
            case (m.nbytes)
                0: begin n.a = rxb; n.nbytes = 1; end
                1: begin n.b = rxb; n.nbytes = 2; end
                default: begin n.op = rxb[5:0]; n.nbytes = 0; n.pipe = 2; end
            endcase
        end else if (m.nbytes != 0) begin
            n.idle = m.idle + 1;
            if (n.idle == int'(TIMEOUT)) begin
                n.timeout = 1'b1;
                n.nbytes  = 0;
                n.idle    = 0;
            end
        end
        return n;
    endfunction

    model_t m = '0;
    logic   mvalid = 1'b0;

    always @(posedge clk) begin
        m      <= step(m, rst, rx_done, rx_data, tx_done);
        mvalid <= mvalid | rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("data_a", data_a, m.a);
            chk("data_b", data_b, m.b);
            chk("opcode", opcode, m.op);
            chk("tx_data", tx_data, m.tx);
            chk("tx_start", tx_start, m.pipe == 1);
            chk("busy", busy, (m.pipe != 0) || m.wait_tx);
            chk("timeout", timeout, m.timeout);
            chk("overrun", overrun, m.overrun);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Counts edges after the opcode tick until o_tx_start, then checks it drops.
    task automatic wait_start(input string name);
        int  edges;
        bit  seen;
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            edges++;
            if (tx_start) seen = 1'b1;
        end
        chk({name, "_start_seen"}, seen, 1);
        // tx_start is sampled in the cycle after the edge that follows the opcode tick.
        chk({name, "_latency_edges"}, edges, 1);
    endtask

    task automatic finish_tx(input string name);
        tick();
        chk({name, "_start_width"}, tx_start, 0);
        idle(2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({name, "_idle_after_tx"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        tick();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("reset_data_a", data_a, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);

        // Basic add.
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        wait_start("add");
        chk("add_a", data_a, 8'h05);
        chk("add_b", data_b, 8'h03);
        chk("add_op", opcode, 6'h20);
        chk("add_tx", tx_data, 8'h08);
        finish_tx("add");

        // Opcode truncation, then wrapping add.
        send_byte(8'h30); send_byte(8'h10); send_byte(8'hE2);
        wait_start("trunc");
        chk("trunc_op", opcode, 6'h22);
        chk("trunc_tx", tx_data, 8'h20);
        finish_tx("trunc");
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h20);
        wait_start("wrap");
        chk("wrap_tx", tx_data, 8'h00);
        finish_tx("wrap");

        // Timeout after a lone operand A.
        send_byte(8'h11);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (timeout) break;
        end
        chk("timeout_edges", n, 16);
        tick();
        chk("timeout_width", timeout, 0);
        chk("timeout_keeps_a", data_a, 8'h11);
        send_byte(8'h02); send_byte(8'h04); send_byte(8'h20);
        wait_start("after_to");
        chk("after_to_tx", tx_data, 8'h06);
        finish_tx("after_to");

        // Bytes landing exactly on the terminal-count cycle are accepted.
        send_byte(8'h33);
        idle(15);
        send_byte(8'h44);
        chk("boundary_no_timeout_b", timeout, 0);
        chk("boundary_b", data_b, 8'h44);
        idle(15);
        send_byte(8'h20);
        chk("boundary_no_timeout_op", timeout, 0);
        wait_start("boundary");
        chk("boundary_tx", tx_data, 8'h77);
        finish_tx("boundary");

        // Overrun during WAIT_TX and on the WAIT_TX exit cycle.
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h20);
        wait_start("ovr");
        tick();
        send_byte(8'hAA);
        chk("ovr_flag", overrun, 1);
        chk("ovr_keeps_a", data_a, 8'h10);
        rx_done = 1'b1;
        rx_data = 8'hBB;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        chk("ovr_exit_idle", busy, 0);
        chk("ovr_exit_keeps_a", data_a, 8'h10);
        send_byte(8'h0C); send_byte(8'h01); send_byte(8'h20);
        wait_start("ovr_next");
        chk("ovr_next_a", data_a, 8'h0C);
        chk("ovr_next_tx", tx_data, 8'h0D);
        chk("ovr_sticky", overrun, 1);
        finish_tx("ovr_next");

        // Reset mid-frame.
        send_byte(8'h07); send_byte(8'h09);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_a", data_a, 0);
        chk("rst_b", data_b, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h20);
        wait_start("rst_next");
        chk("rst_next_tx", tx_data, 8'h02);
        finish_tx("rst_next");

        // Randomized traffic: alternate dense and sparse byte arrival to hit timeouts.
        for (int blk = 0; blk < 48; blk++) begin
            int rxp;
            rxp = (blk % 3 == 0) ? 40 : 4;
            repeat (64) begin
                rx_done = ($urandom_range(0, rxp - 1) == 0);
                rx_data = 8'($urandom);
                tx_done = ($urandom_range(0, 7) == 0);
                rst     = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        rx_done = 1'b0;
        tx_done = 1'b0;
        rst     = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
